// File: rtl/tinychip_pkg.sv
// Shared types for the register-file write path.
// DATA_W / ADDR_W : register width and register address width (4 x 16 register file).
// wb_entry_t      : one pending register write (destination address plus value).
package tinychip_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 2;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Pending-write circular buffer for the writeback unit.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   i_push, i_din       : enqueue one entry (ignored when full)
//   i_pop               : dequeue the head (ignored when empty)
//   o_head              : oldest entry
//   o_count             : occupancy, 0..DEPTH
//   o_rd_ptr            : physical slot of the head, so callers can walk entries by age
//   o_entries, o_valid  : every physical slot and whether it currently holds a pending write
module wb_fifo
  import tinychip_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  wb_entry_t              i_din,
  output wb_entry_t              o_head,
  output logic [CNT_W-1:0]       o_count,
  output logic [PTR_W-1:0]       o_rd_ptr,
  output wb_entry_t [DEPTH-1:0]  o_entries,
  output logic [DEPTH-1:0]       o_valid
);
  wb_entry_t [DEPTH-1:0] r_mem;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  w_push;
  logic                  w_pop;

  assign w_push = i_push && (r_count < CNT_W'(DEPTH));
  assign w_pop  = i_pop  && (r_count != '0);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: slot contents only matter while o_valid says so.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

  assign o_head    = r_mem[r_rd_ptr];
  assign o_count   = r_count;
  assign o_rd_ptr  = r_rd_ptr;
  assign o_entries = r_mem;

  // A slot is live when its distance from the head is below the occupancy.
  for (genvar j = 0; j < DEPTH; j++) begin : g_vld
    logic [PTR_W-1:0] w_age;
    assign w_age      = PTR_W'(j) - r_rd_ptr;
    assign o_valid[j] = ({1'b0, w_age} < r_count);
  end
endmodule

// File: rtl/reg_writeback_unit.sv
// Write-side front end of the 4x16 register file. Results are queued in wb_fifo and
// drained onto the shared reg1/write/write_data port whenever decode is not reading
// through reg1; if decode hogs reg1 for STALL_MAX cycles with work pending, the next
// cycle forces a drain and raises rd_stall so decode retries. Pending values are
// forwarded to decode on both read ports.
// Ports:
//   clk, reset                       : clock, synchronous active-high reset
//   res_valid/res_ready/res_addr/res_data : result bus (valid/ready handshake)
//   rd_req, rd_addr1, rd_addr2       : decode read request and addresses
//   rd_stall                         : decode's reg1 read was pre-empted this cycle
//   rf_reg1, rf_write, rf_write_data : register file shared port
//   byp_hit1/2, byp_data1/2          : youngest pending value for rd_addr1/2
//   pending                          : FIFO occupancy
module reg_writeback_unit
  import tinychip_pkg::*;
#(
  parameter  int DEPTH     = 4,
  parameter  int STALL_MAX = 3,
  localparam int CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              res_valid,
  output logic              res_ready,
  input  logic [ADDR_W-1:0] res_addr,
  input  logic [DATA_W-1:0] res_data,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic              rd_stall,
  output logic [ADDR_W-1:0] rf_reg1,
  output logic              rf_write,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              byp_hit1,
  output logic [DATA_W-1:0] byp_data1,
  output logic              byp_hit2,
  output logic [DATA_W-1:0] byp_data2,
  output logic [CNT_W-1:0]  pending
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int SC_W  = $clog2(STALL_MAX + 1);

  wb_entry_t             w_head;
  wb_entry_t             w_din;
  wb_entry_t [DEPTH-1:0] w_entries;
  logic [DEPTH-1:0]      w_valid;
  logic [CNT_W-1:0]      w_count;
  logic [PTR_W-1:0]      w_rd_ptr;
  logic                  w_empty;
  logic                  w_forced;
  logic                  w_drain;
  logic                  w_push;
  logic                  w_hit1;
  logic                  w_hit2;
  logic [DATA_W-1:0]     w_data1;
  logic [DATA_W-1:0]     w_data2;
  logic [SC_W-1:0]       r_scnt;

  assign w_empty  = (w_count == '0);
  // Budget exhausted: this cycle the write port wins over decode's read.
  assign w_forced = !reset && !w_empty && rd_req && (r_scnt == SC_W'(STALL_MAX));
  assign w_drain  = !reset && !w_empty && (!rd_req || w_forced);

  // Full blocks enqueue even when a drain frees a slot this same cycle.
  assign res_ready = !reset && (w_count < CNT_W'(DEPTH));
  assign w_push    = res_valid && res_ready;
  assign w_din     = '{addr: res_addr, data: res_data};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_push    (w_push),
    .i_pop     (w_drain),
    .i_din     (w_din),
    .o_head    (w_head),
    .o_count   (w_count),
    .o_rd_ptr  (w_rd_ptr),
    .o_entries (w_entries),
    .o_valid   (w_valid)
  );

  always_ff @(posedge clk) begin
    if (reset || w_empty || w_drain) r_scnt <= '0;
    else if (rd_req)                 r_scnt <= r_scnt + 1'b1;
  end

  assign rf_write      = w_drain;
  assign rf_reg1       = w_drain ? w_head.addr : rd_addr1;
  assign rf_write_data = w_drain ? w_head.data : '0;
  assign rd_stall      = w_forced;
  assign pending       = reset ? '0 : w_count;

  // Walk oldest to youngest so the last match is the youngest pending write.
  // The head being drained this cycle is still live; the incoming result is not.
  always_comb begin
    logic [PTR_W-1:0] idx;
    w_hit1  = 1'b0;
    w_hit2  = 1'b0;
    w_data1 = '0;
    w_data2 = '0;
    idx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = w_rd_ptr + PTR_W'(i);
      if (w_valid[idx] && w_entries[idx].addr == rd_addr1) begin
        w_hit1  = 1'b1;
        w_data1 = w_entries[idx].data;
      end
      if (w_valid[idx] && w_entries[idx].addr == rd_addr2) begin
        w_hit2  = 1'b1;
        w_data2 = w_entries[idx].data;
      end
    end
  end

  assign byp_hit1  = !reset && w_hit1;
  assign byp_hit2  = !reset && w_hit2;
  assign byp_data1 = byp_hit1 ? w_data1 : '0;
  assign byp_data2 = byp_hit2 ? w_data2 : '0;
endmodule

// File: tb/tb_reg_writeback_unit.sv
module tb_reg_writeback_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        res_valid;
  logic        res_ready;
  logic [1:0]  res_addr;
  logic [15:0] res_data;
  logic        rd_req;
  logic [1:0]  rd_addr1;
  logic [1:0]  rd_addr2;
  logic        rd_stall;
  logic [1:0]  rf_reg1;
  logic        rf_write;
  logic [15:0] rf_write_data;
  logic        byp_hit1;
  logic [15:0] byp_data1;
  logic        byp_hit2;
  logic [15:0] byp_data2;
  logic [2:0]  pending;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  reg_writeback_unit #(.DEPTH(4), .STALL_MAX(3)) dut (
    .clk(clk), .reset(reset),
    .res_valid(res_valid), .res_ready(res_ready), .res_addr(res_addr), .res_data(res_data),
    .rd_req(rd_req), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_stall(rd_stall),
    .rf_reg1(rf_reg1), .rf_write(rf_write), .rf_write_data(rf_write_data),
    .byp_hit1(byp_hit1), .byp_data1(byp_data1), .byp_hit2(byp_hit2), .byp_data2(byp_data2),
    .pending(pending)
  );

  typedef struct {
    logic        rst, rv;
    logic [1:0]  ra;
    logic [15:0] rd;
    logic        rq;
    logic [1:0]  a1, a2;
    logic        rdy, wr;
    logic [1:0]  reg1;
    logic [15:0] wd;
    logic        stall, h1;
    logic [15:0] d1;
    logic        h2;
    logic [15:0] d2;
    logic [2:0]  pend;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic rv, input logic [1:0] ra, input logic [15:0] rd,
                       input logic rq, input logic [1:0] a1, input logic [1:0] a2);
    reset = rst; res_valid = rv; res_addr = ra; res_data = rd;
    rd_req = rq; rd_addr1 = a1; rd_addr2 = a2;
  endtask

  task automatic chk_all(input int idx, input vec_t v);
    chk("res_ready", idx, 32'(res_ready), 32'(v.rdy));
    chk("rf_write", idx, 32'(rf_write), 32'(v.wr));
    chk("rf_reg1", idx, 32'(rf_reg1), 32'(v.reg1));
    chk("rf_write_data", idx, 32'(rf_write_data), 32'(v.wd));
    chk("rd_stall", idx, 32'(rd_stall), 32'(v.stall));
    chk("byp_hit1", idx, 32'(byp_hit1), 32'(v.h1));
    chk("byp_data1", idx, 32'(byp_data1), 32'(v.d1));
    chk("byp_hit2", idx, 32'(byp_hit2), 32'(v.h2));
    chk("byp_data2", idx, 32'(byp_data2), 32'(v.d2));
    chk("pending", idx, 32'(pending), 32'(v.pend));
  endtask

  initial begin
    //                 rst rv ra rdata     rq a1 a2 | rdy wr reg1 wdata  stl h1 d1        h2 d2        pend
    // reset state
    vecs.push_back(vec_t'{1, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 0});
    // basic write: r3 <= BEEF, drained next cycle, head visible to bypass while draining
    vecs.push_back(vec_t'{0, 1, 3, 16'hBEEF, 0, 0, 0, 1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 0});
    vecs.push_back(vec_t'{0, 0, 0, 16'h0000, 0, 0, 3, 1, 1, 3, 16'hBEEF, 0, 0, 16'h0000, 1, 16'hBEEF, 1});
    // three writes to r1 while decode reads r1: youngest forwarded, then in-order drain
    vecs.push_back(vec_t'{0, 1, 1, 16'h0001, 1, 1, 0, 1, 0, 1, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 0});
    vecs.push_back(vec_t'{0, 1, 1, 16'h0002, 1, 1, 0, 1, 0, 1, 16'h0000, 0, 1, 16'h0001, 0, 16'h0000, 1});
    vecs.push_back(vec_t'{0, 1, 1, 16'h0003, 1, 1, 0, 1, 0, 1, 16'h0000, 0, 1, 16'h0002, 0, 16'h0000, 2});
    vecs.push_back(vec_t'{0, 0, 0, 16'h0000, 1, 1, 2, 1, 0, 1, 16'h0000, 0, 1, 16'h0003, 0, 16'h0000, 3});
    vecs.push_back(vec_t'{0, 0, 0, 16'h0000, 0, 1, 0, 1, 1, 1, 16'h0001, 0, 1, 16'h0003, 0, 16'h0000, 3});
    vecs.push_back(vec_t'{0, 0, 0, 16'h0000, 0, 1, 0, 1, 1, 1, 16'h0002, 0, 1, 16'h0003, 0, 16'h0000, 2});
    vecs.push_back(vec_t'{0, 0, 0, 16'h0000, 0, 1, 0, 1, 1, 1, 16'h0003, 0, 1, 16'h0003, 0, 16'h0000, 1});
    vecs.push_back(vec_t'{0, 0, 0, 16'h0000, 0, 1, 0, 1, 0, 1, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 0});
    // fill to DEPTH with rd_req held; full coincides with forced drain, 5th result refused
    vecs.push_back(vec_t'{0, 1, 0, 16'h0010, 1, 2, 0, 1, 0, 2, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 0});
    vecs.push_back(vec_t'{0, 1, 1, 16'h0011, 1, 2, 0, 1, 0, 2, 16'h0000, 0, 0, 16'h0000, 1, 16'h0010, 1});
    vecs.push_back(vec_t'{0, 1, 2, 16'h0012, 1, 2, 1, 1, 0, 2, 16'h0000, 0, 0, 16'h0000, 1, 16'h0011, 2});
    vecs.push_back(vec_t'{0, 1, 3, 16'h0013, 1, 2, 3, 1, 0, 2, 16'h0000, 0, 1, 16'h0012, 0, 16'h0000, 3});
    vecs.push_back(vec_t'{0, 1, 0, 16'h0014, 1, 3, 0, 0, 1, 0, 16'h0010, 1, 1, 16'h0013, 1, 16'h0010, 4});
    vecs.push_back(vec_t'{0, 1, 0, 16'h0014, 1, 0, 1, 1, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0011, 3});
    // stall counter restarts: 3 lost write slots, then forced drain, repeated twice
    vecs.push_back(vec_t'{0, 0, 0, 16'h0000, 1, 1, 2, 0, 0, 1, 16'h0000, 0, 1, 16'h0011, 1, 16'h0012, 4});
    vecs.push_back(vec_t'{0, 0, 0, 16'h0000, 1, 0, 3, 0, 0, 0, 16'h0000, 0, 1, 16'h0014, 1, 16'h0013, 4});
    vecs.push_back(vec_t'{0, 0, 0, 16'h0000, 1, 2, 1, 0, 1, 1, 16'h0011, 1, 1, 16'h0012, 1, 16'h0011, 4});
    vecs.push_back(vec_t'{0, 0, 0, 16'h0000, 1, 2, 0, 1, 0, 2, 16'h0000, 0, 1, 16'h0012, 1, 16'h0014, 3});
    vecs.push_back(vec_t'{0, 0, 0, 16'h0000, 1, 3, 0, 1, 0, 3, 16'h0000, 0, 1, 16'h0013, 1, 16'h0014, 3});
    vecs.push_back(vec_t'{0, 0, 0, 16'h0000, 1, 3, 3, 1, 0, 3, 16'h0000, 0, 1, 16'h0013, 1, 16'h0013, 3});
    vecs.push_back(vec_t'{0, 0, 0, 16'h0000, 1, 2, 2, 1, 1, 2, 16'h0012, 1, 1, 16'h0012, 1, 16'h0012, 3});
    // refill to full, then drain with res_valid on: full blocks enqueue, next cycle push+pop
    vecs.push_back(vec_t'{0, 1, 1, 16'h0021, 1, 0, 1, 1, 0, 0, 16'h0000, 0, 1, 16'h0014, 0, 16'h0000, 2});
    vecs.push_back(vec_t'{0, 1, 2, 16'h0022, 1, 1, 2, 1, 0, 1, 16'h0000, 0, 1, 16'h0021, 0, 16'h0000, 3});
    vecs.push_back(vec_t'{0, 1, 3, 16'h0023, 0, 3, 0, 0, 1, 3, 16'h0013, 0, 1, 16'h0013, 1, 16'h0014, 4});
    vecs.push_back(vec_t'{0, 1, 3, 16'h0023, 0, 3, 1, 1, 1, 0, 16'h0014, 0, 0, 16'h0000, 1, 16'h0021, 3});
    vecs.push_back(vec_t'{0, 0, 0, 16'h0000, 0, 3, 2, 1, 1, 1, 16'h0021, 0, 1, 16'h0023, 1, 16'h0022, 3});

    drive(1, 0, 0, 16'h0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].rv, vecs[i].ra, vecs[i].rd, vecs[i].rq, vecs[i].a1, vecs[i].a2);
      @(negedge clk);
      chk_all(i, vecs[i]);
      @(posedge clk);
      #1;
    end

    // Reset with {2,22},{3,23} pending and rd_req low: nothing may reach the regfile.
    drive(1, 0, 0, 16'h0, 0, 2, 3);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rst_rf_write", 100 + c, 32'(rf_write), 32'd0);
      chk("rst_wdata", 100 + c, 32'(rf_write_data), 32'd0);
      chk("rst_pending", 100 + c, 32'(pending), 32'd0);
      chk("rst_ready", 100 + c, 32'(res_ready), 32'd0);
      chk("rst_stall", 100 + c, 32'(rd_stall), 32'd0);
      chk("rst_hit1", 100 + c, 32'(byp_hit1), 32'd0);
      chk("rst_hit2", 100 + c, 32'(byp_hit2), 32'd0);
      @(posedge clk);
      #1;
    end
    drive(0, 0, 0, 16'h0, 0, 2, 3);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("post_rst_rf_write", 110 + c, 32'(rf_write), 32'd0);
      chk("post_rst_pending", 110 + c, 32'(pending), 32'd0);
      chk("post_rst_ready", 110 + c, 32'(res_ready), 32'd1);
      chk("post_rst_hit1", 110 + c, 32'(byp_hit1), 32'd0);
      chk("post_rst_hit2", 110 + c, 32'(byp_hit2), 32'd0);
      @(posedge clk);
      #1;
    end
    // Unit still works after a mid-operation reset.
    drive(0, 1, 2, 16'h0055, 0, 0, 0);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 16'h0, 0, 0, 2);
    @(negedge clk);
    chk("recover_write", 120, 32'(rf_write), 32'd1);
    chk("recover_reg1", 120, 32'(rf_reg1), 32'd2);
    chk("recover_wdata", 120, 32'(rf_write_data), 32'h55);
    chk("recover_hit2", 120, 32'(byp_data2), 32'h55);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("recover_empty", 121, 32'(pending), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
